// File: rtl/banked_pingpong_buffer.sv
// banked_pingpong_buffer
// Double-buffered, banked row store. A producer streams scalar words into
// the write half, and each word is scattered across NUM_BANKS banks. At the
// same time the compute side reads full NUM_BANKS-wide rows from the other
// half. If a fill ends mid-row, the rest of that row is zero-padded in one
// extra cycle. An explicit swap exchanges the two halves once a fill is done.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_data   producer word handshake
//   wr_last                     final word of the current fill
//   fill_done, fill_count       write half complete / words accepted so far
//   swap                        exchange halves (acted on only while fill_done)
//   rd_req, rd_addr             row read request into the read half
//   rd_valid, rd_data, rd_oob   read response one cycle later; rd_oob flags
//                               a row at or beyond rd_rows (rd_data forced to 0)
//   rd_rows                     number of valid rows in the read half
module banked_pingpong_buffer #(
    parameter int NUM_BANKS = 64,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 13,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_last,
    output logic                        fill_done,
    output logic [CNT_W-1:0]            fill_count,
    input  logic                        swap,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_valid,
    output logic [NUM_BANKS*DATA_W-1:0] rd_data,
    output logic                        rd_oob,
    output logic [ADDR_W:0]             rd_rows
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, PAD, DONE} stateT;

    stateT                        state, stateNext;
    logic                         wrSel;
    logic [BANK_W-1:0]            bankPtr;
    logic [ADDR_W-1:0]            rowPtr;
    logic [CNT_W-1:0]             fillCount;
    logic [ADDR_W:0]              rowsWritten;
    logic [ADDR_W:0]              rdRows;
    logic                         rdValid;
    logic                         rdOob;
    logic [NUM_BANKS*DATA_W-1:0]  rdDataQ;
    logic                         wrReadyC;
    logic                         fillDoneC;
    logic                         accept;
    logic                         lastSlot;
    logic                         doSwap;
    logic [NUM_BANKS-1:0]         bankWe;
    logic [DATA_W-1:0]            writeData;
    logic                         rdHalf;
    logic [NUM_BANKS*DATA_W-1:0]  rowData;

    assign accept   = wr_valid && wrReadyC;
    assign lastSlot = (bankPtr == LAST_BANK) && (rowPtr == LAST_ROW);
    assign doSwap   = (state == DONE) && swap;
    assign rdHalf   = ~wrSel;

    // Fill sequencing. A fill ends when the last slot is written or when
    // wr_last arrives. If wr_last leaves the row partly filled, one PAD cycle
    // zeroes the rest of that row first.
    always_comb begin
        stateNext = state;
        wrReadyC  = 1'b0;
        fillDoneC = 1'b0;
        unique case (state)
            FILL: begin
                wrReadyC = 1'b1;
                if (wr_valid) begin
                    if (lastSlot || (wr_last && (bankPtr == LAST_BANK))) begin
                        stateNext = DONE;
                    end else if (wr_last) begin
                        stateNext = PAD;
                    end
                end
            end
            PAD: begin
                stateNext = DONE;
            end
            DONE: begin
                fillDoneC = 1'b1;
                if (swap) begin
                    stateNext = FILL;
                end
            end
            default: begin
                stateNext = FILL;
            end
        endcase
    end

    // Per-bank write enables. In FILL only the bank under bankPtr is written.
    // In PAD, bankPtr still points at the last bank written, so every bank
    // above it in the same row is written with zero in a single cycle.
    always_comb begin
        bankWe = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (accept && (bankPtr == BANK_W'(b))) begin
                bankWe[b] = 1'b1;
            end
            if ((state == PAD) && (BANK_W'(b) > bankPtr)) begin
                bankWe[b] = 1'b1;
            end
        end
    end

    assign writeData = (state == PAD) ? '0 : wr_data;

    // Storage: each bank holds both halves. Contents are not reset, because
    // rows outside rd_rows are never returned.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : gBank
        logic [DATA_W-1:0] bankMem [2][DEPTH];

        always_ff @(posedge clk) begin
            if (bankWe[g]) begin
                bankMem[wrSel][rowPtr] <= writeData;
            end
        end

        assign rowData[g*DATA_W +: DATA_W] = bankMem[rdHalf][rd_addr];
    end

    // State register plus scatter pointers and fill bookkeeping. The pointers
    // advance only while the fill continues. On the word that ends the fill
    // they stay put: PAD needs them, and rowsWritten is taken from them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wrSel       <= 1'b0;
            bankPtr     <= '0;
            rowPtr      <= '0;
            fillCount   <= '0;
            rowsWritten <= '0;
            rdRows      <= '0;
        end else begin
            state <= stateNext;
            if (doSwap) begin
                wrSel     <= ~wrSel;
                rdRows    <= rowsWritten;
                bankPtr   <= '0;
                rowPtr    <= '0;
                fillCount <= '0;
            end else if (accept) begin
                fillCount <= fillCount + CNT_W'(1);
                if (stateNext == FILL) begin
                    if (bankPtr == LAST_BANK) begin
                        bankPtr <= '0;
                        rowPtr  <= rowPtr + ADDR_W'(1);
                    end else begin
                        bankPtr <= bankPtr + BANK_W'(1);
                    end
                end else begin
                    rowsWritten <= {1'b0, rowPtr} + (ADDR_W + 1)'(1);
                end
            end
        end
    end

    // Read pipeline with one cycle of latency. It samples the read half as of
    // this edge, so a read issued alongside a swap still returns the old half.
    // rd_data keeps its last value while no request is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdValid <= 1'b0;
            rdOob   <= 1'b0;
            rdDataQ <= '0;
        end else begin
            rdValid <= rd_req;
            if (rd_req) begin
                if ({1'b0, rd_addr} >= rdRows) begin
                    rdOob   <= 1'b1;
                    rdDataQ <= '0;
                end else begin
                    rdOob   <= 1'b0;
                    rdDataQ <= rowData;
                end
            end else begin
                rdOob <= 1'b0;
            end
        end
    end

    assign wr_ready   = wrReadyC;
    assign fill_done  = fillDoneC;
    assign fill_count = fillCount;
    assign rd_rows    = rdRows;
    assign rd_valid   = rdValid;
    assign rd_oob     = rdOob;
    assign rd_data    = rdDataQ;

endmodule

// File: tb/tb_banked_pingpong_buffer.sv
// tb_banked_pingpong_buffer
// Directed bench for banked_pingpong_buffer with a small configuration
// (4 banks x 3 rows). A row model tracks the write half and the read half.
// Each read request pushes its expected row into a scoreboard queue, and the
// entry is popped and compared when rd_valid comes back.
module tb_banked_pingpong_buffer;

    localparam int NB    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 3;
    localparam int AW    = 2;
    localparam int CW    = 4;
    localparam int RW    = NB * DW;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          fill_done;
    logic [CW-1:0] fill_count;
    logic          swap;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [RW-1:0] rd_data;
    logic          rd_oob;
    logic [AW:0]   rd_rows;

    banked_pingpong_buffer #(
        .NUM_BANKS(NB),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .fill_done (fill_done),
        .fill_count(fill_count),
        .swap      (swap),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_oob    (rd_oob),
        .rd_rows   (rd_rows)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] data;
        logic          oob;
    } expT;

    expT           sbQ[$];
    logic [RW-1:0] modelWrite [DEPTH];
    logic [RW-1:0] modelRead  [DEPTH];
    int            modelRows;
    int            modelWords;
    int            modelRowsWritten;
    logic [RW-1:0] lastData;
    int            compareCount;
    int            failCount;

    task automatic checkVal(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pops the expected read for this cycle, if one is due, and compares it.
    task automatic checkOutput();
        expT e;
        checkVal("rd_valid", RW'(rd_valid), RW'(sbQ.size() > 0));
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal("rd_data", rd_data, e.data);
            checkVal("rd_oob", RW'(rd_oob), RW'(e.oob));
            lastData = e.data;
        end
    endtask

    // Drives one cycle using the inputs already set up. The expected read
    // result is pushed from the pre-edge model, then outputs are sampled 1ns
    // after the edge.
    task automatic applyStimulus();
        expT e;
        if (rd_req) begin
            if (int'(rd_addr) >= modelRows) begin
                e.data = '0;
                e.oob  = 1'b1;
            end else begin
                e.data = modelRead[rd_addr];
                e.oob  = 1'b0;
            end
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Sends one word that the DUT will accept in FILL, and scatters it into
    // the write-half model. A new row starts out zeroed, which matches the
    // padding the DUT applies to any unfilled tail of that row.
    task automatic streamWord(input logic [DW-1:0] data, input logic last);
        int bank;
        int row;
        bank = modelWords % NB;
        row  = modelWords / NB;
        if (bank == 0) modelWrite[row] = '0;
        modelWrite[row][bank*DW +: DW] = data;
        modelWords++;
        modelRowsWritten = row + 1;
        wr_valid = 1'b1;
        wr_data  = data;
        wr_last  = last;
        applyStimulus();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Applies a swap that the DUT will act on, then updates the model.
    task automatic doSwap();
        swap = 1'b1;
        applyStimulus();
        swap = 1'b0;
        modelRead  = modelWrite;
        modelRows  = modelRowsWritten;
        modelWords = 0;
    endtask

    task automatic readRow(input int addr);
        rd_req  = 1'b1;
        rd_addr = AW'(addr);
        applyStimulus();
        rd_req  = 1'b0;
    endtask

    initial begin
        compareCount     = 0;
        failCount        = 0;
        modelRows        = 0;
        modelWords       = 0;
        modelRowsWritten = 0;
        lastData         = '0;
        rst_n            = 1'b0;
        wr_valid         = 1'b0;
        wr_data          = '0;
        wr_last          = 1'b0;
        swap             = 1'b0;
        rd_req           = 1'b0;
        rd_addr          = '0;

        // Values held during reset
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkVal("reset wr_ready", RW'(wr_ready), RW'(1));
        checkVal("reset fill_done", RW'(fill_done), RW'(0));
        checkVal("reset fill_count", RW'(fill_count), RW'(0));
        checkVal("reset rd_rows", RW'(rd_rows), RW'(0));
        checkVal("reset rd_valid", RW'(rd_valid), RW'(0));
        checkVal("reset rd_oob", RW'(rd_oob), RW'(0));
        checkVal("reset rd_data", rd_data, RW'(0));
        rst_n = 1'b1;
        applyStimulus();

        // Any read before the first swap is out of range
        readRow(0);
        checkVal("preswap rd_oob", RW'(rd_oob), RW'(1));

        // Reset asserted mid-fill clears state before the next edge
        for (int i = 0; i < 5; i++) streamWord(DW'(16'h0100 + i), 1'b0);
        checkVal("midfill fill_count", RW'(fill_count), RW'(5));
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async wr_ready", RW'(wr_ready), RW'(1));
        checkVal("async fill_count", RW'(fill_count), RW'(0));
        checkVal("async rd_rows", RW'(rd_rows), RW'(0));
        checkVal("async fill_done", RW'(fill_done), RW'(0));
        #1;
        rst_n      = 1'b1;
        modelWords = 0;
        modelRows  = 0;
        sbQ.delete();

        // Full fill: 12 words, no wr_last
        for (int i = 1; i <= 12; i++) streamWord(DW'(i), 1'b0);
        checkVal("full fill_done", RW'(fill_done), RW'(1));
        checkVal("full wr_ready", RW'(wr_ready), RW'(0));
        checkVal("full fill_count", RW'(fill_count), RW'(12));
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        applyStimulus();
        wr_valid = 1'b0;
        checkVal("done blocks write", RW'(fill_count), RW'(12));
        doSwap();
        checkVal("swap1 rd_rows", RW'(rd_rows), RW'(3));
        checkVal("swap1 fill_count", RW'(fill_count), RW'(0));
        checkVal("swap1 wr_ready", RW'(wr_ready), RW'(1));
        readRow(1);
        checkVal("row1 full", rd_data, 64'h0008_0007_0006_0005);
        readRow(2);

        // Partial fill: 6 words ending mid-row, so one PAD cycle follows
        for (int i = 1; i <= 6; i++) streamWord(DW'(16'h00A0 + i), i == 6);
        checkVal("pad wr_ready", RW'(wr_ready), RW'(0));
        checkVal("pad fill_done", RW'(fill_done), RW'(0));
        applyStimulus();
        checkVal("after pad fill_done", RW'(fill_done), RW'(1));
        doSwap();
        checkVal("swap2 rd_rows", RW'(rd_rows), RW'(2));
        readRow(1);
        checkVal("row1 padded", rd_data, 64'h0000_0000_00A6_00A5);
        readRow(0);
        readRow(2);
        checkVal("row2 oob", RW'(rd_oob), RW'(1));
        checkVal("row2 zero", rd_data, RW'(0));
        readRow(3);

        // A swap during FILL is ignored and not remembered
        for (int i = 1; i <= 3; i++) streamWord(DW'(16'h00B0 + i), 1'b0);
        swap = 1'b1;
        applyStimulus();
        swap = 1'b0;
        checkVal("ignored swap fill_count", RW'(fill_count), RW'(3));
        checkVal("ignored swap rd_rows", RW'(rd_rows), RW'(2));
        checkVal("ignored swap wr_ready", RW'(wr_ready), RW'(1));
        streamWord(16'h00B4, 1'b0);
        checkVal("count continues", RW'(fill_count), RW'(4));
        for (int i = 5; i <= 8; i++) streamWord(DW'(16'h00B0 + i), i == 8);
        checkVal("last at row end done", RW'(fill_done), RW'(1));
        checkVal("last at row end count", RW'(fill_count), RW'(8));

        // Back-to-back reads across a swap
        rd_req  = 1'b1;
        rd_addr = '0;
        applyStimulus();
        doSwap();
        checkVal("swap-cycle read old", rd_data, 64'h00A4_00A3_00A2_00A1);
        applyStimulus();
        checkVal("post-swap read new", rd_data, 64'h00B4_00B3_00B2_00B1);
        rd_req = 1'b0;
        applyStimulus();
        checkVal("rd_data hold", rd_data, lastData);
        checkVal("swap3 rd_rows", RW'(rd_rows), RW'(2));
        checkVal("scoreboard drained", RW'(sbQ.size()), RW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
